coax_tx_bit_timer_ext: RTL

Next-generation coax TX bit timer with a runtime-programmable bit period, word-level bit counting and a graceful start/stop protocol. It generates the half-bit phase, mid-bit and end-of-bit strobes that drive the TX Manchester encoder and serializer, plus a word boundary strobe. It replaces the fixed CLOCKS_PER_BIT timer in the TX path.

---
 rtl/coax_tx_bit_timer_ext.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/coax_tx_bit_timer_ext.sv
// coax_tx_bit_timer_ext: programmable coax TX bit timer.
// Generates the half-bit phase, mid-bit and end-of-bit strobes for the
// Manchester encoder and serializer. It also generates a word boundary strobe
// and the bit index within the word.
//
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   enable                        level request for continuous bit timing
//   clocks_per_bit                bit period in clocks (min 2), sampled at counter 0
//   bits_per_word                 word length in bits (0 -> 1), sampled at word start
//   active                        bit period in progress
//   first_half / second_half      half-bit phase (second half gets extra clock on odd N)
//   mid_strobe / end_strobe       first clock of second half / last clock of bit
//   word_end_strobe               end_strobe of the last bit in the word
//   bit_index                     index of the current bit within the word
//   adjust (optional)             01 lengthen / 10 shorten current bit by one clock
//
// Optional feature macro: COAX_TX_BIT_TIMER_ADJUST_EN (adds the adjust input).
// All outputs are registered. They are computed from the next-cycle counter.
module coax_tx_bit_timer_ext #(
  parameter int unsigned CPB_WIDTH       = 8,
  parameter int unsigned BIT_INDEX_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [CPB_WIDTH-1:0]       clocks_per_bit,
  input  logic [BIT_INDEX_WIDTH-1:0] bits_per_word,
`ifdef COAX_TX_BIT_TIMER_ADJUST_EN
  input  logic [1:0]                 adjust,
`endif
  output logic                       active,
  output logic                       first_half,
  output logic                       second_half,
  output logic                       mid_strobe,
  output logic                       end_strobe,
  output logic                       word_end_strobe,
  output logic [BIT_INDEX_WIDTH-1:0] bit_index
);

  // One extra bit so that a lengthened maximum period still fits.
  localparam int unsigned NW = CPB_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, RUN, LAST} state_t;

  state_t                     state_q, state_d;
  logic [CPB_WIDTH-1:0]       cnt_q, cnt_d;
  logic [NW-1:0]              n_q, n_d, cur_n;
  logic [CPB_WIDTH-1:0]       h_q, h_d, cur_h;
  logic [BIT_INDEX_WIDTH-1:0] w_q, w_d, cur_w, idx_d;
  logic                       active_d, fh_d, sh_d, mid_d, end_d, wend_d;
  logic                       is_end, last_bit;
`ifdef COAX_TX_BIT_TIMER_ADJUST_EN
  logic                       adj_done_q, adj_done_d;
`endif

  // Next-state, latch points and next-cycle output values.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = bit_index;
    active_d = 1'b0;
    fh_d     = 1'b0;
    sh_d     = 1'b0;
    mid_d    = 1'b0;
    end_d    = 1'b0;
    wend_d   = 1'b0;
    cur_n    = n_q;
    cur_h    = h_q;
    cur_w    = w_q;
    is_end   = 1'b0;
    last_bit = 1'b0;
`ifdef COAX_TX_BIT_TIMER_ADJUST_EN
    adj_done_d = adj_done_q;
`endif

    // Counter 0 is the latch point for the period and, at word start, the word length.
    if (state_q != IDLE && cnt_q == '0) begin
      cur_n = (clocks_per_bit < CPB_WIDTH'(2)) ? NW'(2) : NW'(clocks_per_bit);
      cur_h = CPB_WIDTH'(cur_n >> 1);
      if (bit_index == '0)
        cur_w = (bits_per_word == '0) ? BIT_INDEX_WIDTH'(1) : bits_per_word;
`ifdef COAX_TX_BIT_TIMER_ADJUST_EN
      adj_done_d = 1'b0;
`endif
    end

`ifdef COAX_TX_BIT_TIMER_ADJUST_EN
    // First non-zero request in the first half moves the end point. H stays fixed.
    if (first_half && !adj_done_d) begin
      if (adjust == 2'b01) begin
        cur_n      = cur_n + NW'(1);
        adj_done_d = 1'b1;
      end else if (adjust == 2'b10) begin
        if (cur_n > NW'(2)) cur_n = cur_n - NW'(1);
        adj_done_d = 1'b1;
      end
    end
`endif

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d  = RUN;
          cnt_d    = '0;
          active_d = 1'b1;
          fh_d     = 1'b1;
        end
      end
      default: begin
        is_end   = (NW'(cnt_q) == cur_n - NW'(1));
        last_bit = (bit_index == cur_w - BIT_INDEX_WIDTH'(1));
        if (is_end) begin
          cnt_d = '0;
          if (enable) begin
            // Seamless back-to-back bit.
            state_d  = RUN;
            active_d = 1'b1;
            fh_d     = 1'b1;
            idx_d    = last_bit ? '0 : bit_index + BIT_INDEX_WIDTH'(1);
          end else begin
            // Stop: partial word abandoned.
            state_d = IDLE;
            idx_d   = '0;
          end
        end else begin
          state_d  = enable ? RUN : LAST;
          cnt_d    = cnt_q + CPB_WIDTH'(1);
          active_d = 1'b1;
          fh_d     = (cnt_d < cur_h);
          sh_d     = !fh_d;
          mid_d    = (cnt_d == cur_h);
          end_d    = (NW'(cnt_d) == cur_n - NW'(1));
          wend_d   = end_d && last_bit;
        end
      end
    endcase

    n_d = cur_n;
    h_d = cur_h;
    w_d = cur_w;
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      n_q             <= NW'(2);
      h_q             <= CPB_WIDTH'(1);
      w_q             <= BIT_INDEX_WIDTH'(1);
      active          <= 1'b0;
      first_half      <= 1'b0;
      second_half     <= 1'b0;
      mid_strobe      <= 1'b0;
      end_strobe      <= 1'b0;
      word_end_strobe <= 1'b0;
      bit_index       <= '0;
`ifdef COAX_TX_BIT_TIMER_ADJUST_EN
      adj_done_q      <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      n_q             <= n_d;
      h_q             <= h_d;
      w_q             <= w_d;
      active          <= active_d;
      first_half      <= fh_d;
      second_half     <= sh_d;
      mid_strobe      <= mid_d;
      end_strobe      <= end_d;
      word_end_strobe <= wend_d;
      bit_index       <= idx_d;
`ifdef COAX_TX_BIT_TIMER_ADJUST_EN
      adj_done_q      <= adj_done_d;
`endif
    end
  end

endmodule
